flt_multiplier_decomposable_pipe: RTL

FLT_MULTIPLIER_DECOMPOSABLE_PIPE -- requirements
Module: flt_multiplier_decomposable_pipe

---
 rtl/flt_multiplier_decomposable_pipe.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/flt_multiplier_decomposable_pipe.sv
// Decomposable floating-point mantissa/exponent multiplier: one wide lane or 2^m narrower lanes,
// selected per operand set, carried through an elastic valid/ready pipeline of PIPE_STAGES registers.
module flt_multiplier_decomposable_pipe #(
    parameter int N_PARTS     = 4,
    parameter int PART_L      = 8,
    parameter int EXP_L       = 8,
    parameter int PIPE_STAGES = 2,
    localparam int LOG_N  = $clog2(N_PARTS),
    localparam int MODE_L = (LOG_N == 0) ? 1 : $clog2(LOG_N + 1),
    localparam int W      = N_PARTS * PART_L,
    localparam int OUT_W  = W + 2 * N_PARTS,
    localparam int EW     = EXP_L + 1,
    localparam int EXO_W  = N_PARTS * EW
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [MODE_L-1:0]        mode,
    input  logic [W-1:0]             mant_in_0,
    input  logic [W-1:0]             mant_in_1,
    input  logic [N_PARTS*EXP_L-1:0] exp_in_0,
    input  logic [N_PARTS*EXP_L-1:0] exp_in_1,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [MODE_L-1:0]        mode_out,
    output logic [OUT_W-1:0]         mant_out,
    output logic [EXO_W-1:0]         exp_out,
    output logic [N_PARTS-1:0]       ovf,
    output logic [N_PARTS-1:0]       unf,
    output logic                     mode_err
);

    localparam logic signed [EXP_L:0] EXP_MAX = EW'(2 ** (EXP_L - 1) - 1);
    localparam logic signed [EXP_L:0] EXP_MIN = EW'(-(2 ** (EXP_L - 1)));

    typedef struct packed {
        logic [MODE_L-1:0]  mode;
        logic               err;
        logic [OUT_W-1:0]   mant;
        logic [EXO_W-1:0]   exp;
        logic [N_PARTS-1:0] ovf;
        logic [N_PARTS-1:0] unf;
    } stage_t;

    logic [LOG_N:0][OUT_W-1:0] w_mant_m;
    stage_t                    w_stage_in;
    logic [N_PARTS-1:0]        w_mask;
    logic                      w_legal;
    logic signed [EXP_L:0]     w_sum;
    logic [PIPE_STAGES-1:0]    w_ready;

    stage_t                    r_data [PIPE_STAGES];
    logic [PIPE_STAGES-1:0]    r_valid;

    // One packed result per lane split; each lane keeps the top LW+2 bits of its 2*LW product.
    for (genvar m = 0; m <= LOG_N; m++) begin : g_mode
        localparam int LANES = 1 << m;
        localparam int LW    = W / LANES;
        logic [OUT_W-1:0] w_lane_mant;

        always_comb begin
            // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
            w_lane_mant = '0;
            for (int i = 0; i < LANES; i++) begin
                w_lane_mant[i*(LW+2) +: LW+2] =
                    (LW+2)'(((2*LW)'(mant_in_0[i*LW +: LW]) * (2*LW)'(mant_in_1[i*LW +: LW])) >> (LW - 2));
            end
        end

        assign w_mant_m[m] = w_lane_mant;
    end

    always_comb begin
        w_stage_in = '0;
        w_mask     = '0;
        w_legal    = 1'b0;
        w_sum      = '0;
        for (int m = 0; m <= LOG_N; m++) begin
            if (mode == MODE_L'(m)) begin
                w_legal         = 1'b1;
                w_stage_in.mant = w_mant_m[m];
                for (int i = 0; i < N_PARTS; i++) begin
                    w_mask[i] = (i < (1 << m));
                end
            end
        end
        w_stage_in.mode = mode;
        w_stage_in.err  = !w_legal;
        // Exponents are summed one bit wider than the inputs so the flags can see past the legal range.
        for (int i = 0; i < N_PARTS; i++) begin
            w_sum = EW'($signed(exp_in_0[i*EXP_L +: EXP_L])) + EW'($signed(exp_in_1[i*EXP_L +: EXP_L]));
            if (w_mask[i]) begin
                w_stage_in.exp[i*EW +: EW] = w_sum;
                w_stage_in.ovf[i]          = (w_sum > EXP_MAX);
                w_stage_in.unf[i]          = (w_sum < EXP_MIN);
            end
        end
    end

    // A stage may load when it is empty or some stage downstream of it has room.
    always_comb begin
        for (int s = 0; s < PIPE_STAGES; s++) begin
            w_ready[s] = out_ready;
            for (int t = s; t < PIPE_STAGES; t++) begin
                if (!r_valid[t]) begin
                    w_ready[s] = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= '0;
            // NOTE: stage data is reset too because the last stage drives the outputs, which must read zero in reset.
            for (int s = 0; s < PIPE_STAGES; s++) begin
                r_data[s] <= '0;
            end
        end else begin
            // NOTE: non-blocking assignments let every stage sample the pre-edge value of the stage before it.
            if (w_ready[0]) begin
                r_valid[0] <= in_valid;
                r_data[0]  <= w_stage_in;
            end
            for (int s = 1; s < PIPE_STAGES; s++) begin
                if (w_ready[s]) begin
                    r_valid[s] <= r_valid[s-1];
                    r_data[s]  <= r_data[s-1];
                end
            end
        end
    end

    assign in_ready  = w_ready[0];
    assign out_valid = r_valid[PIPE_STAGES-1];
    assign mode_out  = r_data[PIPE_STAGES-1].mode;
    assign mode_err  = r_data[PIPE_STAGES-1].err;
    assign mant_out  = r_data[PIPE_STAGES-1].mant;
    assign exp_out   = r_data[PIPE_STAGES-1].exp;
    assign ovf       = r_data[PIPE_STAGES-1].ovf;
    assign unf       = r_data[PIPE_STAGES-1].unf;

endmodule
